// File: rtl/opcodes.sv
// Function codes and flag layout shared by the 16-bit ALU and every block that drives it.
`ifndef FLAGS_C
`define FLAGS_C 0
`endif

package opcodes;

    typedef enum logic [3:0] {
        FnMem = 4'd0,
        FnADD = 4'd1,
        FnSUB = 4'd2,
        FnAND = 4'd3,
        FnOR  = 4'd4,
        FnXOR = 4'd5,
        FnLSL = 4'd6,
        FnLSR = 4'd7
    } alu_functions_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier that borrows the shared 16-bit ALU
// for one add and one shift per multiplier bit.
module alu_mul_seq #(
    parameter int NBITS = 16
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   Start,
    input  logic [15:0]            Mcand,
    input  logic [15:0]            Mplier,
    output logic                   Busy,
    output logic                   Done,
    output logic [31:0]            Product,
    output logic                   AluReq,
    output opcodes::alu_functions_t AluOp,
    output logic [15:0]            AluOp1,
    output logic [15:0]            AluOp2,
    input  logic [15:0]            AluResult,
    input  logic [3:0]             AluFlags
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] CNT_LAST  = 5'(NBITS - 1);
    localparam int         SHIFT_OUT = 16 - NBITS;

    state_t      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] m_q, m_d;
    logic        c_q, c_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    // Only the carry flag matters to this block.
    logic unused_flags;
    assign unused_flags = ^AluFlags;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other one, independent of order.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        AluOp     = opcodes::FnMem;
        AluOp1    = '0;
        AluOp2    = '0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    m_d     = Mcand;
                    lo_d    = Mplier;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                // FnMem passes Hi through with carry 0 when this bit is clear.
                AluOp   = lo_q[0] ? opcodes::FnADD : opcodes::FnMem;
                AluOp1  = hi_q;
                AluOp2  = m_q;
                hi_d    = AluResult;
                c_d     = AluFlags[`FLAGS_C];
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                AluOp  = opcodes::FnLSR;
                AluOp1 = hi_q;
                hi_d   = {c_q, AluResult[14:0]};
                lo_d   = {hi_q[0], lo_q[15:1]};
                c_d    = 1'b0;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    // With fewer than 16 bits consumed the product still sits
                    // left-aligned in {Hi,Lo}; realign it on the way out.
                    product_d = {hi_d, lo_d} >> SHIFT_OUT;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign AluReq  = Busy;
    assign Done    = (state_q == S_DONE);
    assign Product = product_q;

endmodule
